// File: rtl/sargantana_icache_pkg.sv
// Shared icache types: ifill request/response payloads plus the ifill responder
// state enum and beat geometry.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_PADDR_W    = 40;
  localparam int unsigned ICACHE_LINE_W     = 512;
  localparam int unsigned ICACHE_WAY_W      = 2;
  localparam int unsigned ICACHE_LINE_OFF_W = 6;

  localparam int unsigned IFILL_BEATS       = 4;
  localparam int unsigned IFILL_BEAT_W      = 128;
  localparam int unsigned IFILL_BEAT_IDX_W  = $clog2(IFILL_BEATS);

  typedef struct packed {
    logic                      valid;
    logic [ICACHE_PADDR_W-1:0] paddr;
    logic [ICACHE_WAY_W-1:0]   way;
  } ifill_req_o_t;

  typedef struct packed {
    logic                      valid;
    logic [ICACHE_PADDR_W-1:0] paddr;
  } ifill_inv_t;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_LINE_W-1:0]    data;
    logic [IFILL_BEAT_IDX_W-1:0] beat;
    ifill_inv_t                  inv;
  } ifill_resp_i_t;

  typedef enum logic [2:0] {
    IFR_IDLE = 3'd0,
    IFR_INV  = 3'd1,
    IFR_REQ  = 3'd2,
    IFR_DATA = 3'd3,
    IFR_RESP = 3'd4,
    IFR_COOL = 3'd5
  } ifill_responder_state_t;

  // Clear the byte-in-line offset so the memory read starts at the line base.
  function automatic logic [ICACHE_PADDR_W-1:0] ifill_line_align(
    input logic [ICACHE_PADDR_W-1:0] paddr
  );
    return {paddr[ICACHE_PADDR_W-1:ICACHE_LINE_OFF_W], ICACHE_LINE_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/sargantana_ifill_line_buffer.sv
// BEATS x BEAT_W line assembly buffer: per-beat write enable, synchronous clear,
// whole line presented flat with beat 0 in the least significant bits.
module sargantana_ifill_line_buffer #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_clr,
  input  logic [BEATS-1:0]        i_we,
  input  logic [BEAT_W-1:0]       i_data,
  output logic [BEATS*BEAT_W-1:0] o_line
);

  logic [BEATS-1:0][BEAT_W-1:0] r_mem;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_mem <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (i_we[b]) begin
          r_mem[b] <= i_data;
        end
      end
    end
  end

  assign o_line = r_mem;

endmodule

// File: rtl/sargantana_icache_ifill_responder.sv
// Memory-side end of the icache ifill interface: turns a line-fill request into a
// beat-oriented memory read, assembles the line, and forwards invalidations.
module sargantana_icache_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned BEATS   = IFILL_BEATS,
  parameter int unsigned BEAT_W  = IFILL_BEAT_W,
  parameter int unsigned PADDR_W = ICACHE_PADDR_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  ifill_req_o_t       ifill_req_i,
  output ifill_resp_i_t      ifill_resp_o,
  input  logic               inv_valid_i,
  input  logic [PADDR_W-1:0] inv_paddr_i,
  output logic               inv_ready_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [BEAT_W-1:0]  mem_rsp_data_i,
  input  logic               mem_rsp_last_i,
  output logic               busy_o,
  output logic               protocol_err_o
);

  localparam int unsigned CNT_W   = $clog2(BEATS);
  localparam int unsigned LINE_W  = BEATS * BEAT_W;
  localparam int unsigned QUIET_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

  ifill_responder_state_t r_state;
  ifill_responder_state_t w_state_nxt;

  logic [PADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [QUIET_W-1:0] r_quiet;
  logic               r_err;

  logic               w_inv_take;
  logic               w_fill_take;
  logic               w_beat_we;
  logic               w_last_err;
  logic               w_nolast_err;
  logic               w_stray_err;
  logic [BEATS-1:0]   w_we_vec;
  logic [LINE_W-1:0]  w_line;
  logic               w_unused_way;

  assign w_unused_way = ^ifill_req_i.way;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= IFR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the per-cycle strobes that steer the datapath registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_inv_take   = 1'b0;
    w_fill_take  = 1'b0;
    w_beat_we    = 1'b0;
    w_last_err   = 1'b0;
    w_nolast_err = 1'b0;
    case (r_state)
      IFR_IDLE: begin
        if (inv_valid_i) begin
          w_inv_take  = 1'b1;
          w_state_nxt = IFR_INV;
        end else if (ifill_req_i.valid) begin
          w_fill_take = 1'b1;
          w_state_nxt = IFR_REQ;
        end
      end
      IFR_INV: begin
        w_state_nxt = IFR_IDLE;
      end
      IFR_REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = IFR_DATA;
        end
      end
      IFR_DATA: begin
        if (mem_rsp_valid_i) begin
          w_beat_we = 1'b1;
          if (mem_rsp_last_i) begin
            w_state_nxt = IFR_RESP;
            w_last_err  = (r_cnt != CNT_MAX);
          end else if (r_cnt == CNT_MAX) begin
            w_state_nxt  = IFR_RESP;
            w_nolast_err = 1'b1;
          end
        end
      end
      IFR_RESP: begin
        w_state_nxt = IFR_COOL;
      end
      IFR_COOL: begin
        w_state_nxt = IFR_IDLE;
      end
      default: begin
        w_state_nxt = IFR_IDLE;
      end
    endcase
  end

  // Beats after a reset may belong to an abandoned read; stay quiet for BEATS cycles.
  assign w_stray_err = mem_rsp_valid_i && (r_state != IFR_DATA) && (r_quiet == '0);
  assign w_we_vec    = w_beat_we ? (BEATS'(1) << r_cnt) : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_quiet <= QUIET_W'(BEATS);
      r_err   <= 1'b0;
    end else begin
      if (w_inv_take) begin
        r_addr <= inv_paddr_i;
      end else if (w_fill_take) begin
        r_addr <= PADDR_W'(ifill_line_align(ICACHE_PADDR_W'(ifill_req_i.paddr)));
      end

      if (w_fill_take) begin
        r_cnt <= '0;
      end else if (w_beat_we) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_quiet != '0) begin
        r_quiet <= r_quiet - QUIET_W'(1);
      end

      if (w_last_err || w_nolast_err || w_stray_err) begin
        r_err <= 1'b1;
      end
    end
  end

  sargantana_ifill_line_buffer #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_line_buffer (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_clr  (w_fill_take),
    .i_we   (w_we_vec),
    .i_data (mem_rsp_data_i),
    .o_line (w_line)
  );

  // Outputs decode the state register and select registered payloads.
  always_comb begin
    ifill_resp_o = '0;
    if (r_state == IFR_INV) begin
      ifill_resp_o.valid     = 1'b1;
      ifill_resp_o.inv.valid = 1'b1;
      ifill_resp_o.inv.paddr = ICACHE_PADDR_W'(r_addr);
    end else if (r_state == IFR_RESP) begin
      ifill_resp_o.valid = 1'b1;
      ifill_resp_o.data  = ICACHE_LINE_W'(w_line);
      ifill_resp_o.beat  = IFILL_BEAT_IDX_W'(BEATS - 1);
    end
  end

  assign inv_ready_o     = (r_state == IFR_IDLE);
  assign busy_o          = (r_state != IFR_IDLE);
  assign mem_req_valid_o = (r_state == IFR_REQ);
  assign mem_req_addr_o  = (r_state == IFR_REQ) ? r_addr : '0;
  assign protocol_err_o  = r_err;

endmodule
